fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the RV32I core, directly upstream of the decoder.
- Holds the PC and issues single-outstanding word requests to instruction memory.
- Registers each returned word with its PC into a one-entry output slot that drives the decoder's `ir` input under a valid/ready handshake.
- Handles control-flow redirects from execute and stops fetching permanently once a halt instruction is consumed.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `imem_req` output 1: fetch request valid.
- `imem_addr` output 32: word address of request, equals current PC.
- `imem_ready` input 1: memory accepts request this cycle.
- `imem_rvalid` input 1: response word valid.
- `imem_rdata` input 32: instruction word.
- `redirect_valid` input 1: taken branch / jump from execute.
- `redirect_pc` input 32: target PC; bits [1:0] ignored, forced to 0.
- `halt` input 1: decoder `is_halt` for the word currently on `ir`.
- `ir_valid` output 1: output slot holds a valid instruction.
- `ir` output 32: instruction word to decoder.
- `ir_pc` output 32: PC of `ir`.
- `ir_ready` input 1: downstream consumes slot this cycle.
- `halted` output 1: fetch permanently stopped.
- `fetch_count` output 32: present only with `FETCH_PERF_CNT_EN`.

## Operation
- **States:** REQ, WAIT, HALTED. State `drop` is 1 bit.
- **Consume:** `ir_valid && ir_ready`.
- **`imem_req`** = (state==REQ) && !redirect_valid && (!ir_valid || ir_ready). It is combinational; `imem_addr` = pc.
- **REQ:**
  - `imem_req && imem_ready` → WAIT.
  - Otherwise stay in REQ.
- **WAIT:**
  - On `imem_rvalid && !drop`: `ir`<=`imem_rdata`, `ir_pc`<=pc, `ir_valid`<=1, pc<=pc+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0), → REQ.
  - On `imem_rvalid && drop`: discard word, `drop`<=0, pc unchanged, → REQ.
- **Redirect** (highest priority, any state except HALTED):
  - pc<={redirect_pc[31:2],2'b00}.
  - `ir_valid`<=0, so the slot is flushed even if consumed that same cycle.
  - If in WAIT and `imem_rvalid` is low, `drop`<=1.
  - If in WAIT and `imem_rvalid` is high, the word is discarded and the FSM goes to REQ with `drop`=0.
- **Halt:**
  - Consume with `halt`=1 and no redirect: `ir_valid`<=0 → HALTED.
  - If in WAIT, the pending response is discarded on arrival.
  - HALTED is exited only by reset.
  - `halt` is ignored when not consuming.
- **Output slot:**
  - Consume without a new fill: `ir_valid`<=0.
  - Fill and consume in the same cycle: `ir_valid` stays 1 with the new word.
  - `ir`/`ir_pc` hold their values while `ir_valid && !ir_ready`.
- A response arriving while the slot is full cannot occur, because requests are issued only when the slot is free or being freed.
- `imem_rvalid` in REQ or HALTED (protocol violation) is ignored.

## Timing
- **Reset values:** pc=RESET_PC, state=REQ, drop=0, `ir_valid`=0, `ir`=0, `ir_pc`=0, `halted`=0, `imem_req` becomes 1 on the first cycle after reset deassertion, `fetch_count`=0.
- **Reset mid-transaction:** all state returns to the reset values asynchronously; the outstanding response is the memory's responsibility to squash.
- **Latency:** request accepted in cycle N, `imem_rvalid` arrives in cycle N+k (k≥1), `ir_valid` is high in cycle N+k+1, and the next `imem_req` is in cycle N+k+1.
- **Throughput:** with k=1 and `ir_ready`=1, one instruction every 2 cycles.
- **Redirect:** the target is requested in the cycle after `redirect_valid` when in REQ. When in WAIT, it is requested in the cycle after the stale response returns.
- `halted` is high in the cycle after the halting consume.

## Configuration
- **`FETCH_PERF_CNT_EN` defined:**
  - `fetch_count` port exists.
  - It increments by 1 per non-dropped response written to the slot and wraps at 2^32.
  - Reset clears it; redirects and halt do not.
- **Undefined:** port and counter are absent; all other behaviour is identical.

## Test plan
- Reset with RESET_PC=32'h100, `imem_ready`=1, k=1, `ir_ready`=1, words A,B,C → `imem_addr` 100,104,108; `ir`/`ir_pc` = A/100, B/104, C/108; one instruction every 2 cycles.
- Backpressure: `ir_ready`=0 for 5 cycles with `ir`=A → `ir` held, no `imem_req` during the stall; the request for 104 is issued in the cycle `ir_ready` returns.
- Redirect in WAIT to 32'h203 with response delayed 3 cycles → stale word not presented; next `imem_addr`=200, `ir_pc`=200.
- Halt: consume with `halt`=1 → `halted`=1 next cycle; `imem_req` stays 0 for 20 cycles; an in-flight response is ignored; a `rst_n` pulse restarts at RESET_PC.
- Wrap: redirect to 32'hFFFF_FFFC → next fetch `imem_addr`=0.
- `FETCH_PERF_CNT_EN`: 10 delivered words plus 1 dropped → `fetch_count`=10.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem requests, one-entry output slot.
// Optional fetch counter enabled with FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        ir_valid,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    input  logic        ir_ready,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] fetch_count,
`endif
    output logic        halted
);

    typedef enum logic [1:0] {StReq, StWait, StHalted} state_e;

    state_e      state;
    logic [31:0] pc;
    logic        drop;
    logic        consume;
    logic [31:0] target;

    assign consume   = ir_valid && ir_ready;
    assign target    = redirect_pc & ~32'h3;
    assign imem_addr = pc;
    assign imem_req  = (state == StReq) && !redirect_valid && (!ir_valid || ir_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StReq;
            pc       <= RESET_PC;
            drop     <= 1'b0;
            ir_valid <= 1'b0;
            ir       <= 32'h0;
            ir_pc    <= 32'h0;
            halted   <= 1'b0;
        end else begin
            if (consume) begin
                ir_valid <= 1'b0;
            end
            case (state)
                StReq: begin
                    if (redirect_valid) begin
                        pc       <= target;
                        ir_valid <= 1'b0;
                    end else if (consume && halt) begin
                        // A request accepted this same cycle is left to die in HALTED
                        state    <= StHalted;
                        halted   <= 1'b1;
                        ir_valid <= 1'b0;
                    end else if (imem_req && imem_ready) begin
                        state <= StWait;
                    end
                end
                StWait: begin
                    if (redirect_valid) begin
                        pc       <= target;
                        ir_valid <= 1'b0;
                        if (imem_rvalid) begin
                            drop  <= 1'b0;
                            state <= StReq;
                        end else begin
                            drop <= 1'b1;
                        end
                    end else if (consume && halt) begin
                        state    <= StHalted;
                        halted   <= 1'b1;
                        ir_valid <= 1'b0;
                    end else if (imem_rvalid) begin
                        state <= StReq;
                        if (drop) begin
                            drop <= 1'b0;
                        end else begin
                            ir       <= imem_rdata;
                            ir_pc    <= pc;
                            ir_valid <= 1'b1;
                            pc       <= pc + 32'd4;
                        end
                    end
                end
                StHalted: begin
                end
                default: state <= StReq;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic fill;

    // Mirrors the slot-write condition of the WAIT branch above
    assign fill = (state == StWait) && imem_rvalid && !drop && !redirect_valid
                  && !(consume && halt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 32'h0;
        end else if (fill) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with RESET_PC = 32'h100; inputs change 2 time units after
// each rising edge and outputs are checked 1 unit later.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        ir_valid;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_ready;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    fetch_unit #(
        .RESET_PC(32'h0000_0100)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .ir_valid       (ir_valid),
        .ir             (ir),
        .ir_pc          (ir_pc),
        .ir_ready       (ir_ready),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count    (fetch_count),
`endif
        .halted         (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One fetch with k=1: request at addr a accepted now, word w returned next cycle.
    task automatic do_fetch(input string tag, input logic [31:0] a, input logic [31:0] w);
        #1;
        chk({tag, "_req"}, {31'h0, imem_req}, 32'h1);
        chk({tag, "_addr"}, imem_addr, a);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = w;
        #1;
        chk({tag, "_wait_noreq"}, {31'h0, imem_req}, 32'h0);
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        #1;
        chk({tag, "_valid"}, {31'h0, ir_valid}, 32'h1);
        chk({tag, "_ir"}, ir, w);
        chk({tag, "_ir_pc"}, ir_pc, a);
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_ready     = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        ir_ready       = 1'b0;
        tick();
        tick();
        chk("rst_ir_valid", {31'h0, ir_valid}, 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_ir_pc", ir_pc, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        chk("rst_addr", imem_addr, 32'h100);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_count", fetch_count, 32'h0);
`endif
        rst_n      = 1'b1;
        imem_ready = 1'b1;
        ir_ready   = 1'b1;

        // Streaming, one instruction every 2 cycles
        do_fetch("a", 32'h100, 32'hAAAA_0001);
        do_fetch("b", 32'h104, 32'hBBBB_0002);
        do_fetch("c", 32'h108, 32'hCCCC_0003);

        // Backpressure; halt must be ignored while nothing is consumed
        ir_ready = 1'b0;
        halt     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_noreq", {31'h0, imem_req}, 32'h0);
            chk("stall_ir", ir, 32'hCCCC_0003);
            chk("stall_valid", {31'h0, ir_valid}, 32'h1);
            tick();
        end
        halt     = 1'b0;
        ir_ready = 1'b1;
        chk("stall_not_halted", {31'h0, halted}, 32'h0);
        do_fetch("d", 32'h10C, 32'hDDDD_0004);

        // Redirect while WAIT, stale response 3 cycles later
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("redir_wait_noreq", {31'h0, imem_req}, 32'h0);
            chk("redir_flushed", {31'h0, ir_valid}, 32'h0);
            tick();
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        #1;
        chk("stale_not_shown", {31'h0, ir_valid}, 32'h0);
        do_fetch("e", 32'h200, 32'hEEEE_0005);

        // Redirect in REQ to the top word, then wrap to 0
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        #1;
        chk("redir_blocks_req", {31'h0, imem_req}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1;
        chk("redir_req_flush", {31'h0, ir_valid}, 32'h0);
        do_fetch("f", 32'hFFFF_FFFC, 32'hFFFF_0006);
        do_fetch("g", 32'h0000_0000, 32'h6666_0007);
`ifdef FETCH_PERF_CNT_EN
        chk("count_7", fetch_count, 32'd7);
`endif

        // Halt on consume; the request accepted in the same cycle is left in flight
        halt = 1'b1;
        tick();
        halt = 1'b0;
        #1;
        chk("halted", {31'h0, halted}, 32'h1);
        chk("halt_flush", {31'h0, ir_valid}, 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        tick();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            redirect_valid = (i == 3);
            redirect_pc    = 32'h300;
            #1;
            chk("halt_noreq", {31'h0, imem_req}, 32'h0);
            chk("halt_noslot", {31'h0, ir_valid}, 32'h0);
            tick();
        end
        redirect_valid = 1'b0;
        chk("halt_still", {31'h0, halted}, 32'h1);
        chk("halt_pc", imem_addr, 32'h4);
`ifdef FETCH_PERF_CNT_EN
        chk("count_after_halt", fetch_count, 32'd7);
`endif

        // Asynchronous reset pulse restarts at RESET_PC
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_halted", {31'h0, halted}, 32'h0);
        chk("arst_addr", imem_addr, 32'h100);
`ifdef FETCH_PERF_CNT_EN
        chk("arst_count", fetch_count, 32'h0);
`endif
        tick();
        rst_n = 1'b1;
        do_fetch("h", 32'h100, 32'h8888_0008);
`ifdef FETCH_PERF_CNT_EN
        chk("count_1", fetch_count, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
